// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(15,11) transmit path.
//   DATA_W     : data bits per word fed to the encoder
//   CODE_W     : encoded codeword width
//   tx_state_t : serializer FSM states
package hamming_pkg;

    localparam int DATA_W = 11;
    localparam int CODE_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_t;

endpackage

// File: rtl/hamming_word_fifo.sv
// Small synchronous word FIFO with registered full/empty flags.
//   clk, RST   : clock, asynchronous active-low reset
//   push/wr_data : write request and data (ignored when full)
//   pop/rd_data  : read request (ignored when empty); rd_data shows the head word
//   level_next   : occupancy after the current edge, for registering status elsewhere
//   full, empty  : registered status flags
module hamming_word_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   level_next,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   level_reg;
    logic          full_reg;
    logic          empty_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full_reg;
    assign do_pop  = pop && !empty_reg;

    // Simultaneous push and pop leaves the level unchanged.
    always_comb begin
        level_next = level_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
            full_reg  <= (level_next == (AW+1)'(DEPTH));
            empty_reg <= (level_next == '0);
        end
    end

    // Head word is visible combinationally so the serializer can load it
    // on the same edge that pops it.
    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/hamming_tx_serializer.sv
// Buffers parallel data words and shifts them out MSB first as a serial
// stream for a Hamming(15,11) encoder, with optional idle gap between words.
//   clk, RST    : clock, asynchronous active-low reset
//   in_data/in_valid/in_ready : word input handshake (in_ready = registered !full)
//   sl_out      : serial data bit
//   shift       : strobe marking each valid serial bit
//   frame_start : high with the first (MSB) bit of each word
//   busy        : serializing, in gap, or words pending
module hamming_tx_serializer #(
    parameter int DATA_W     = hamming_pkg::DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sl_out,
    output logic              shift,
    output logic              frame_start,
    output logic              busy
);
    import hamming_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [3:0]    BIT_LAST = 4'(DATA_W - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_t         state_reg, state_next;
    logic [DATA_W-1:0] sreg_reg, sreg_next;
    logic [3:0]        bit_cnt_reg, bit_cnt_next;
    logic [GW-1:0]     gap_cnt_reg, gap_cnt_next;
    logic              sl_out_reg, sl_out_next;
    logic              shift_reg, shift_next;
    logic              frame_start_reg, frame_start_next;
    logic              busy_reg, busy_next;
    logic              in_ready_reg, in_ready_next;

    logic              push;
    logic              pop;
    logic              pick_next;
    logic [DATA_W-1:0] fifo_data;
    logic [LW-1:0]     fifo_level_next;
    logic              fifo_full;
    logic              fifo_empty;

    assign push = in_valid && in_ready_reg;

    hamming_word_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .RST        (RST),
        .push       (push),
        .wr_data    (in_data),
        .pop        (pop),
        .rd_data    (fifo_data),
        .level_next (fifo_level_next),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        state_next       = state_reg;
        sreg_next        = sreg_reg;
        bit_cnt_next     = bit_cnt_reg;
        gap_cnt_next     = gap_cnt_reg;
        sl_out_next      = 1'b0;
        shift_next       = 1'b0;
        frame_start_next = 1'b0;
        pop              = 1'b0;
        pick_next        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                pick_next = 1'b1;
            end
            ST_SHIFT: begin
                // Outputs are registered, so the bit held at the MSB now
                // appears on sl_out after this edge.
                sl_out_next      = sreg_reg[DATA_W-1];
                shift_next       = 1'b1;
                frame_start_next = (bit_cnt_reg == 4'd0);
                sreg_next        = sreg_reg << 1;
                if (bit_cnt_reg == BIT_LAST) begin
                    bit_cnt_next = 4'd0;
                    if (GAP_CYCLES > 0) begin
                        state_next   = ST_GAP;
                        gap_cnt_next = '0;
                    end else begin
                        pick_next = 1'b1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == GAP_LAST) begin
                    gap_cnt_next = '0;
                    pick_next    = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Shared frame-boundary decision: load the next word or go idle.
        if (pick_next) begin
            if (!fifo_empty) begin
                pop          = 1'b1;
                sreg_next    = fifo_data;
                bit_cnt_next = 4'd0;
                state_next   = ST_SHIFT;
            end else begin
                state_next = ST_IDLE;
            end
        end

        busy_next     = shift_next || (state_next != ST_IDLE) || (fifo_level_next != '0);
        // Follows the FIFO's own full flag timing: no early ready on a pop.
        in_ready_next = (fifo_level_next != LW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg       <= ST_IDLE;
            sreg_reg        <= '0;
            bit_cnt_reg     <= 4'd0;
            gap_cnt_reg     <= '0;
            sl_out_reg      <= 1'b0;
            shift_reg       <= 1'b0;
            frame_start_reg <= 1'b0;
            busy_reg        <= 1'b0;
            in_ready_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sreg_reg        <= sreg_next;
            bit_cnt_reg     <= bit_cnt_next;
            gap_cnt_reg     <= gap_cnt_next;
            sl_out_reg      <= sl_out_next;
            shift_reg       <= shift_next;
            frame_start_reg <= frame_start_next;
            busy_reg        <= busy_next;
            in_ready_reg    <= in_ready_next;
        end
    end

    assign in_ready    = in_ready_reg;
    assign sl_out      = sl_out_reg;
    assign shift       = shift_reg;
    assign frame_start = frame_start_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Bench for hamming_tx_serializer: instance 0 has no inter-word gap,
// instance 1 inserts a 3-cycle gap. A word-level scoreboard (queue of
// accepted words) is compared against words rebuilt from the serial stream.
module tb_hamming_tx_serializer;

    typedef logic [10:0] word_t;

    typedef struct {
        string name;
        word_t data;
        word_t seq;   // expected serial bits, first-transmitted bit at [10]
    } vec_t;

    logic  clk = 1'b0;
    logic  RST = 1'b1;
    word_t in_data     [2];
    logic  in_valid    [2];
    logic  in_ready    [2];
    logic  sl_out      [2];
    logic  shift       [2];
    logic  frame_start [2];
    logic  busy        [2];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            hamming_tx_serializer #(
                .DATA_W     (11),
                .FIFO_DEPTH (2),
                .GAP_CYCLES (gi * 3)
            ) dut (
                .clk         (clk),
                .RST         (RST),
                .in_data     (in_data[gi]),
                .in_valid    (in_valid[gi]),
                .in_ready    (in_ready[gi]),
                .sl_out      (sl_out[gi]),
                .shift       (shift[gi]),
                .frame_start (frame_start[gi]),
                .busy        (busy[gi])
            );
        end
    endgenerate

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard ----------------
    word_t exp_q0[$];
    word_t exp_q1[$];
    int    rx_cnt[2];
    int    shift_seen[2];
    int    nbits[2];
    word_t acc[2];

    function automatic int exp_size(input int i);
        return (i == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic word_t exp_pop(input int i);
        if (i == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    always @(posedge clk) begin
        if (RST) begin
            if (in_valid[0] && in_ready[0]) exp_q0.push_back(in_data[0]);
            if (in_valid[1] && in_ready[1]) exp_q1.push_back(in_data[1]);
        end
    end

    // Rebuild words from the serial stream and check framing rules.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                nbits[i] = 0;
            end else if (shift[i]) begin
                check($sformatf("mon%0d_frame_start", i), 32'(frame_start[i]), 32'(nbits[i] == 0));
                acc[i] = {acc[i][9:0], sl_out[i]};
                nbits[i]++;
                shift_seen[i]++;
                if (nbits[i] == 11) begin
                    nbits[i] = 0;
                    rx_cnt[i]++;
                    check($sformatf("mon%0d_word_expected", i), 32'(exp_size(i) != 0), 32'd1);
                    if (exp_size(i) != 0)
                        check($sformatf("mon%0d_word_order", i), 32'(acc[i]), 32'(exp_pop(i)));
                end
            end else begin
                // Outside a word the stream is quiet and never breaks mid-word.
                check($sformatf("mon%0d_idle_outputs", i),
                      {29'd0, nbits[i] != 0, sl_out[i], frame_start[i]}, 32'd0);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int i);
        int cyc = 0;
        while (busy[i] && cyc < 200) begin
            tick();
            cyc++;
        end
        check($sformatf("idle%0d_reached", i), 32'(busy[i]), 32'd0);
    endtask

    task automatic single_word(input int i, input vec_t v);
        check({v.name, "_ready"}, 32'(in_ready[i]), 32'd1);
        in_data[i]  = v.data;
        in_valid[i] = 1'b1;
        @(posedge clk);                      // edge k
        #1;
        in_valid[i] = 1'b0;
        tick();                              // after k+1: nothing yet
        check({v.name, "_lat_k1_shift"}, 32'(shift[i]), 32'd0);
        check({v.name, "_busy"}, 32'(busy[i]), 32'd1);
        for (int j = 0; j < 11; j++) begin
            tick();                          // after k+2+j
            check($sformatf("%s_b%0d_shift", v.name, j), 32'(shift[i]), 32'd1);
            check($sformatf("%s_b%0d_sl", v.name, j), 32'(sl_out[i]), 32'(v.seq[10-j]));
            check($sformatf("%s_b%0d_fs", v.name, j), 32'(frame_start[i]), 32'(j == 0));
        end
        tick();
        check({v.name, "_end_shift"}, 32'(shift[i]), 32'd0);
        wait_idle(i);
    endtask

    task automatic push_two(input int i, input word_t a, input word_t b);
        in_data[i]  = a;
        in_valid[i] = 1'b1;
        @(posedge clk);
        #1;
        in_data[i] = b;
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    task automatic drive_random(input int i, input int n);
        int cyc;
        for (int k = 0; k < n; k++) begin
            in_valid[i] = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            in_data[i]  = word_t'($urandom);
            in_valid[i] = 1'b1;
            cyc = 0;
            while (!in_ready[i] && cyc < 100) begin
                tick();
                cyc++;
            end
            check($sformatf("rand%0d_accept_timeout", i), 32'(in_ready[i]), 32'd1);
            tick();
        end
        in_valid[i] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[5];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    rx0;
        int    shifts0;
        int    n;
        int    cyc;
        logic  acc_r;
        logic  saw_low;
        word_t bp [4];

        vecs[0] = '{"w5A3", 11'h5A3, 11'b101_1010_0011};
        vecs[1] = '{"w7FF", 11'h7FF, 11'b111_1111_1111};
        vecs[2] = '{"w001", 11'h001, 11'b000_0000_0001};
        vecs[3] = '{"w400", 11'h400, 11'b100_0000_0000};
        vecs[4] = '{"w555", 11'h555, 11'b101_0101_0101};

        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = '0;
        end

        // Reset state
        #1 RST = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_outputs", i),
                  {27'd0, in_ready[i], sl_out[i], shift[i], frame_start[i], busy[i]}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 RST = 1'b1;
        check("rel_ready_before_edge", 32'(in_ready[0]), 32'd0);
        tick();
        check("rel_ready0_after_edge", 32'(in_ready[0]), 32'd1);
        check("rel_ready1_after_edge", 32'(in_ready[1]), 32'd1);
        check("rel_busy0", 32'(busy[0]), 32'd0);

        // Single words on both gap settings
        for (int v = 0; v < 5; v++)
            for (int i = 0; i < 2; i++)
                single_word(i, vecs[v]);

        // Back-to-back streaming, no gap
        push_two(0, 11'h7FF, 11'h000);       // now after k+1
        for (int j = 0; j < 22; j++) begin
            tick();
            check($sformatf("b2b_%0d_shift", j), 32'(shift[0]), 32'd1);
            check($sformatf("b2b_%0d_sl", j), 32'(sl_out[0]), 32'(j < 11));
            check($sformatf("b2b_%0d_fs", j), 32'(frame_start[0]), 32'((j % 11) == 0));
        end
        tick();
        check("b2b_end_shift", 32'(shift[0]), 32'd0);
        wait_idle(0);

        // 3-cycle gap between two words
        push_two(1, 11'h5A3, 11'h2C7);
        for (int j = 0; j < 25; j++) begin
            tick();
            if (j >= 11 && j < 14) begin
                check($sformatf("gap_%0d_quiet", j), {30'd0, shift[1], sl_out[1]}, 32'd0);
            end else begin
                check($sformatf("gap_%0d_shift", j), 32'(shift[1]), 32'd1);
                check($sformatf("gap_%0d_fs", j), 32'(frame_start[1]), 32'(j == 0 || j == 14));
            end
        end
        tick();
        check("gap_end_shift", 32'(shift[1]), 32'd0);
        wait_idle(1);

        // Backpressure: valid held with four distinct words
        bp[0] = 11'h123; bp[1] = 11'h456; bp[2] = 11'h789; bp[3] = 11'h0AB;
        rx0 = rx_cnt[0];
        n = 0; cyc = 0; saw_low = 1'b0;
        while (n < 4 && cyc < 200) begin
            in_data[0]  = bp[n];
            in_valid[0] = 1'b1;
            acc_r = in_ready[0];
            if (!acc_r) saw_low = 1'b1;
            tick();
            if (acc_r) n++;
            cyc++;
        end
        in_valid[0] = 1'b0;
        check("bp_ready_dropped", 32'(saw_low), 32'd1);
        check("bp_all_accepted", 32'(n), 32'd4);
        wait_idle(0);
        check("bp_rx_count", 32'(rx_cnt[0] - rx0), 32'd4);

        // Reset in the middle of a word
        in_data[0]  = 11'h7FF;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (6) tick();                   // five bits out
        check("mid_shift_active", 32'(shift[0]), 32'd1);
        #1 RST = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        #1;
        check("mid_rst_outputs",
              {27'd0, in_ready[0], sl_out[0], shift[0], frame_start[0], busy[0]}, 32'd0);
        @(posedge clk);
        #1 RST = 1'b1;
        check("mid_rel_busy", 32'(busy[0]), 32'd0);
        shifts0 = shift_seen[0];
        repeat (20) tick();
        check("mid_no_residual", 32'(shift_seen[0] - shifts0), 32'd0);
        check("mid_ready_back", 32'(in_ready[0]), 32'd1);

        // Random end-to-end traffic on both instances
        fork
            drive_random(0, 40);
            drive_random(1, 40);
        join
        wait_idle(0);
        wait_idle(1);
        repeat (2) tick();
        check("rand_q0_drained", 32'(exp_q0.size()), 32'd0);
        check("rand_q1_drained", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
